inst_mem_sync: RTL
==================

Name: inst_mem_sync

Overview:
- Parametrised, synchronous-read instruction memory for the pipelined core's IF stage.
- Successor to the combinational, hard-initialised instruction ROM.
- Adds:
  - registered 1-cycle fetch with stall/flush control;
  - word- or byte-addressed PC mode;
  - out-of-range detection;
  - a streaming program-loader port (valid/ready) driven by a small FSM, so test programs load at run time instead of being hard-coded.

Parameters:
- DATA_W, 32, instruction width in bits
- DEPTH, 1024, number of instruction words
- ADDR_W, 32, width of pc and ld_base
- BYTE_ADDR, 0, 0 = pc is a word index; 1 = pc is a byte address, index = pc[ADDR_W-1:2]
- NOP_WORD, 32'h00000000, value driven on flush, during load, and on out-of-range fetch

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- pc  in  ADDR_W  fetch address
- fetch_en  in  1  request a fetch this cycle
- stall  in  1  hold inst/inst_valid
- flush  in  1  kill the registered instruction
- inst  out  DATA_W  fetched instruction (registered)
- inst_valid  out  1  inst is a real fetch result
- addr_err  out  1  1-cycle pulse: fetch index >= DEPTH
- ld_start  in  1  pulse: begin program load
- ld_base  in  ADDR_W  first word index written by the load
- ld_valid  in  1  ld_data valid
- ld_ready  out  1  loader accepts a word
- ld_data  in  DATA_W  program word
- ld_last  in  1  marks the final word (qualified by ld_valid)
- ld_busy  out  1  loader not IDLE
- ld_done  out  1  1-cycle pulse when load completes
- ld_ovf  out  1  1-cycle pulse: a handshaked word was dropped (index >= DEPTH)

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - Outputs: inst=NOP_WORD, inst_valid=0, addr_err=0, ld_ready=0, ld_busy=0, ld_done=0, ld_ovf=0.
  - FSM goes to IDLE; load counter cleared.
  - Memory array contents are NOT cleared.
- Fetch index: idx = BYTE_ADDR ? pc>>2 : pc.
- Fetch register (IDLE only). Per edge, first matching row wins:
  1. flush → inst=NOP_WORD, inst_valid=0.
  2. stall → hold inst and inst_valid.
  3. fetch_en with idx<DEPTH → inst=mem[idx], inst_valid=1.
  4. fetch_en with idx>=DEPTH → inst=NOP_WORD, inst_valid=1, addr_err=1.
  5. otherwise → inst_valid=0, inst holds.
- Fetch latency: exactly 1 cycle (pc sampled at edge N, inst visible after edge N).
- FSM state IDLE:
  - ld_ready=0.
  - ld_start → LOAD; cnt=ld_base.
  - A fetch in the same cycle as ld_start still completes normally.
- FSM state LOAD:
  - ld_ready=1, ld_busy=1; fetch blocked; inst=NOP_WORD, inst_valid=0 unless stall holds them.
  - flush still clears inst/inst_valid during LOAD.
  - Handshake = ld_valid & ld_ready.
  - On handshake: if cnt<DEPTH, write mem[cnt]=ld_data; else drop the word and pulse ld_ovf. Then cnt=cnt+1 (ADDR_W wrap, no saturation).
  - Handshake with ld_last → DONE.
  - ld_start during LOAD is ignored.
- FSM state DONE:
  - One cycle only: ld_done=1, ld_busy=1, ld_ready=0; then → IDLE.
  - The first fetch is accepted in the cycle after DONE.
- Reset mid-load: immediate return to IDLE; words already written remain; no ld_done.
- No read/write collision is possible: fetch and load are mutually exclusive by state.

Optional Feature:
- Macro: INST_MEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit computed on loader write.
  - On an in-range fetch, recomputed parity is compared; a mismatch drives extra output parity_err=1 registered alongside inst (same cycle as inst_valid), else 0.
  - parity_err resets to 0, holds on stall, clears on flush.
- Undefined: no parity storage, no parity_err port; behaviour otherwise identical.

Test Plan:
- Reset then load: ld_start, ld_base=0; stream 8C080000, 8C090008, 8C0A0014, 8C0B0002 with ld_last on the 4th word → ld_done pulses exactly once, 1 cycle after the last handshake; ld_busy falls next cycle.
- Fetch word mode: BYTE_ADDR=0, pc=0,1,2,3 on consecutive cycles → inst = loaded words 1 cycle later, inst_valid=1 each cycle.
- Byte mode: BYTE_ADDR=1, pc=0x8 → inst=mem[2]=8C0A0014.
- Stall/flush:
  - Fetch pc=1, then stall 3 cycles → inst holds 8C090008, inst_valid=1.
  - flush with stall=1 → inst=00000000, inst_valid=0.
- Boundaries:
  - DEPTH=1024, fetch pc=1024 → inst=NOP, inst_valid=1, addr_err 1-cycle pulse.
  - Load ld_base=1023 with 2 words → mem[1023] written, ld_ovf pulses on the 2nd word.
- Reset mid-load: 2 of 4 words sent, rst=1 → ld_busy=0, no ld_done; fetching those 2 indices returns the new data, the next index returns its old contents.

Source files
------------

// File: rtl/inst_mem_sync.sv
// Synchronous-read instruction memory with a registered 1-cycle fetch and a streaming program loader.
// Define INST_MEM_PARITY_EN to add per-word even parity and the parity_err output.
module inst_mem_sync #(
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 1024,
  parameter int                ADDR_W    = 32,
  parameter int                BYTE_ADDR = 0,
  parameter logic [DATA_W-1:0] NOP_WORD  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              fetch_en,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid,
  output logic              addr_err,
`ifdef INST_MEM_PARITY_EN
  output logic              parity_err,
`endif
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_busy,
  output logic              ld_done,
  output logic              ld_ovf
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] idx;
  logic              idx_ok, cnt_ok, hs;
  logic [DATA_W-1:0] mem [DEPTH];

  assign idx    = (BYTE_ADDR != 0) ? (pc >> 2) : pc;
  assign idx_ok = {1'b0, idx} < DEPTH_X;
  assign cnt_ok = {1'b0, cnt} < DEPTH_X;
  assign hs     = ld_valid & ld_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_ready  = 1'b0;
    ld_busy   = 1'b0;
    ld_done   = 1'b0;
    case (state)
      IDLE: if (ld_start) state_nxt = LOAD;
      LOAD: begin
        ld_ready = 1'b1;
        ld_busy  = 1'b1;
        if (ld_valid && ld_last) state_nxt = DONE;
      end
      DONE: begin
        ld_busy   = 1'b1;
        ld_done   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Load pointer wraps at ADDR_W; out-of-range words are dropped, not clamped.
  always_ff @(posedge clk) begin
    if (rst)                          cnt <= '0;
    else if (state == IDLE && ld_start) cnt <= ld_base;
    else if (hs)                      cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst && hs && cnt_ok) mem[cnt[IW-1:0]] <= ld_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst       <= NOP_WORD;
      inst_valid <= 1'b0;
      addr_err   <= 1'b0;
      ld_ovf     <= 1'b0;
    end else begin
      addr_err <= 1'b0;
      ld_ovf   <= hs & ~cnt_ok;
      if (flush) begin
        inst       <= NOP_WORD;
        inst_valid <= 1'b0;
      end else if (stall) begin
        inst       <= inst;
        inst_valid <= inst_valid;
      end else if (state == IDLE && fetch_en) begin
        inst_valid <= 1'b1;
        if (idx_ok) inst <= mem[idx[IW-1:0]];
        else begin
          inst     <= NOP_WORD;
          addr_err <= 1'b1;
        end
      end else if (state != IDLE) begin
        inst       <= NOP_WORD;
        inst_valid <= 1'b0;
      end else begin
        inst_valid <= 1'b0;
      end
    end
  end

`ifdef INST_MEM_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst && hs && cnt_ok) par_mem[cnt[IW-1:0]] <= ^ld_data;
  end

  always_ff @(posedge clk) begin
    if (rst || flush)                      parity_err <= 1'b0;
    else if (stall)                        parity_err <= parity_err;
    else if (state == IDLE && fetch_en && idx_ok)
      parity_err <= (^mem[idx[IW-1:0]]) != par_mem[idx[IW-1:0]];
    else                                   parity_err <= 1'b0;
  end
`endif

endmodule
